// File: rtl/race_sample_feeder_pkg.sv
// race_sample_feeder_pkg: shared defaults and FSM encoding for the sample feeder.
package race_sample_feeder_pkg;
    localparam int W_DEF = 16;
    localparam int UF_W = 16;
    typedef enum logic {ST_FILL = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/race_sample_feeder_if.sv
// race_sample_feeder_if: valid/ready complex sample stream from the source into the feeder.
interface race_sample_feeder_if #(parameter int W = 16) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] re;
    logic [W-1:0] im;
    modport master (output valid, output re, output im, input ready);
    modport slave (input valid, input re, input im, output ready);
endinterface

// File: rtl/race_sample_feeder_fifo.sv
// race_cplx_fifo: circular buffer of complex samples with occupancy count.
module race_cplx_fifo #(
    parameter int W = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       push_i,
    input  logic [2*W-1:0]             wdata_i,
    input  logic                       pop_i,
    output logic [2*W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [2*W-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [LW-1:0]  level_q;
    logic           do_push, do_pop;
    assign full_o  = level_q == LW'(DEPTH);
    assign empty_o = level_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_q];
    assign level_o = level_q;
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= do_push ? wr_q + 1'b1 : wr_q;
            rd_q    <= do_pop ? rd_q + 1'b1 : rd_q;
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/race_sample_feeder.sv
// race_sample_feeder: buffers a bursty sample stream and emits one sample per divided strobe,
// zero-filling and counting underflows when the buffer runs dry.
module race_sample_feeder
    import race_sample_feeder_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int DIV = 20,
    parameter int DEPTH = 8,
    parameter int PREFILL = 4
) (
    input  logic                   clk,
    input  logic                   nrst,
    race_sample_feeder_if.slave    src,
    output logic                   strobe_o,
    output logic [W-1:0]           out_real_o,
    output logic [W-1:0]           out_imag_o,
    output logic                   out_valid_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   underflow_o,
    output logic [UF_W-1:0]        underflow_cnt_o
);
    localparam int CW = $clog2(DIV);
    localparam int LW = $clog2(DEPTH) + 1;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            strobe_q;
    logic [W-1:0]    re_q, re_d, im_q, im_d;
    logic            valid_q, valid_d;
    logic            uf_q, uf_d;
    logic [UF_W-1:0] ufc_q, ufc_d;
    logic            tick, take, full, empty;
    logic [2*W-1:0]  head;
    logic [LW-1:0]   level;
    assign src.ready = nrst && !full;
    race_cplx_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push_i  (src.valid && src.ready),
        .wdata_i ({src.re, src.im}),
        .pop_i   (take),
        .rdata_o (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );
    // The load edge is the edge on which strobe rises, so data and strobe appear together.
    assign tick = cnt_q == CW'(DIV - 1);
    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        take    = tick && (state_q == ST_RUN ? !empty : level >= LW'(PREFILL));
        uf_d    = tick && state_q == ST_RUN && empty;
        state_d = tick ? (take ? ST_RUN : ST_FILL) : state_q;
        re_d    = tick ? (take ? head[2*W-1:W] : '0) : re_q;
        im_d    = tick ? (take ? head[W-1:0] : '0) : im_q;
        valid_d = tick ? take : valid_q;
        ufc_d   = (uf_d && ufc_q != '1) ? ufc_q + 1'b1 : ufc_q;
    end
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= ST_FILL;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            re_q     <= '0;
            im_q     <= '0;
            valid_q  <= 1'b0;
            uf_q     <= 1'b0;
            ufc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= tick;
            re_q     <= re_d;
            im_q     <= im_d;
            valid_q  <= valid_d;
            uf_q     <= uf_d;
            ufc_q    <= ufc_d;
        end
    end
    assign strobe_o        = strobe_q;
    assign out_real_o      = re_q;
    assign out_imag_o      = im_q;
    assign out_valid_o     = valid_q;
    assign level_o         = level;
    assign underflow_o     = uf_q;
    assign underflow_cnt_o = ufc_q;
endmodule

// File: tb/tb_race_sample_feeder.sv
// tb_race_sample_feeder: directed and random stimulus checked each cycle against a queue-based model.
module tb_race_sample_feeder;
    localparam int W = 16;
    localparam int DIV = 20;
    localparam int DEPTH = 8;
    localparam int PREFILL = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic strobe, out_valid, underflow;
    logic [W-1:0] out_real, out_imag;
    logic [3:0] level;
    logic [15:0] ufc;

    race_sample_feeder_if #(.W(W)) bus ();

    race_sample_feeder #(.W(W), .DIV(DIV), .DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .src             (bus),
        .strobe_o        (strobe),
        .out_real_o      (out_real),
        .out_imag_o      (out_imag),
        .out_valid_o     (out_valid),
        .level_o         (level),
        .underflow_o     (underflow),
        .underflow_cnt_o (ufc)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    logic [31:0] q[$];
    int edges = 0;
    bit filling = 1;
    bit m_strobe = 0, m_valid = 0, m_uf = 0, last_acc = 0;
    logic [W-1:0] m_re = '0, m_im = '0;
    int m_ufc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit acc;
        acc = nrst && bus.valid && q.size() < DEPTH;
        @(posedge clk);
        if (!nrst) begin
            q.delete();
            edges = 0; filling = 1; m_strobe = 0; m_valid = 0; m_uf = 0;
            m_re = '0; m_im = '0; m_ufc = 0; acc = 0;
        end else begin
            edges++;
            m_strobe = (edges % DIV) == 0;
            m_uf = 0;
            if (m_strobe) begin
                if (filling ? q.size() >= PREFILL : q.size() > 0) begin
                    {m_re, m_im} = q.pop_front();
                    m_valid = 1;
                    filling = 0;
                end else begin
                    m_re = '0; m_im = '0; m_valid = 0;
                    if (!filling) begin
                        m_uf = 1;
                        if (m_ufc < 65535) m_ufc++;
                    end
                    filling = 1;
                end
            end
            if (acc) q.push_back({bus.re, bus.im});
        end
        last_acc = acc;
        #1;
        chk("strobe", 32'(strobe), 32'(m_strobe));
        chk("out_real", 32'(out_real), 32'(m_re));
        chk("out_imag", 32'(out_imag), 32'(m_im));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("level", 32'(level), 32'(q.size()));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("underflow_cnt", 32'(ufc), 32'(m_ufc));
        chk("in_ready", 32'(bus.ready), 32'(nrst && q.size() != DEPTH));
    endtask

    task automatic idle(input int n);
        bus.valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic push_seq(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            bus.valid = 1'b1;
            bus.re = W'(base + i);
            bus.im = W'(-(base + i));
            step();
        end
        bus.valid = 1'b0;
    endtask

    task automatic burst(input int n, inout int nxt);
        repeat (n) begin
            bus.valid = 1'b1;
            bus.re = W'(nxt);
            bus.im = ~W'(nxt);
            step();
            if (last_acc) nxt++;
        end
        bus.valid = 1'b0;
    endtask

    initial begin
        int nxt;
        int rates[5] = '{3, 5, 8, 20, 60};
        bus.valid = 1'b0; bus.re = '0; bus.im = '0;
        nrst = 1'b0;
        repeat (2) step();
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_ready", 32'(bus.ready), 32'd0);
        nrst = 1'b1;
        idle(2 * DIV + 3);
        push_seq(3, 1);
        idle(2 * DIV);
        chk("prefill_no_data", 32'(out_valid), 32'd0);
        push_seq(1, 4);
        idle(6 * DIV);
        chk("first_underflow_cnt", 32'(ufc), 32'd1);
        push_seq(3, 10);
        idle(3 * DIV);
        chk("refill_three_no_data", 32'(out_valid), 32'd0);
        push_seq(1, 13);
        idle(6 * DIV);
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        nxt = 1;
        burst(12, nxt);
        chk("burst_level_full", 32'(level), 32'd8);
        chk("burst_ready_low", 32'(bus.ready), 32'd0);
        chk("burst_accepted", 32'(nxt - 1), 32'd8);
        burst(16 * DIV, nxt);
        for (int r = 0; r < 5; r++) begin
            repeat (500) begin
                bus.valid = $urandom_range(0, 99) < rates[r];
                bus.re = W'($urandom);
                bus.im = W'($urandom);
                step();
            end
        end
        bus.valid = 1'b0;
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        push_seq(5, 100);
        chk("pre_reset_level", 32'(level), 32'd5);
        nrst = 1'b0;
        step();
        chk("mid_reset_level", 32'(level), 32'd0);
        chk("mid_reset_ufc", 32'(ufc), 32'd0);
        chk("mid_reset_out", {out_real, out_imag}, 32'd0);
        nrst = 1'b1;
        idle(3 * DIV);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
